// File: rtl/regfile.sv
// Architectural register file with per-register rename tags. Lookups are
// combinational, with commit bypass and ROB forwarding on busy registers.
module regfile #(
    parameter int ROB_WIDTH = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 dec_ready,
    input  logic [4:0]           issue_rd,
    input  logic [ROB_WIDTH-1:0] issue_rob_id,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    output logic [31:0]          val1,
    output logic [31:0]          val2,
    output logic                 has_dep1,
    output logic                 has_dep2,
    output logic [ROB_WIDTH-1:0] dep1,
    output logic [ROB_WIDTH-1:0] dep2,
    output logic [ROB_WIDTH-1:0] search_rob_id_1,
    output logic [ROB_WIDTH-1:0] search_rob_id_2,
    input  logic                 search_ready_1,
    input  logic                 search_ready_2,
    input  logic [31:0]          search_val_1,
    input  logic [31:0]          search_val_2,
    input  logic                 commit_valid,
    input  logic [ROB_WIDTH-1:0] commit_rob_id,
    input  logic [4:0]           commit_reg_id,
    input  logic [31:0]          commit_val
);

    typedef struct packed {
        logic [31:0]          val;
        logic                 has_dep;
        logic [ROB_WIDTH-1:0] dep;
        logic [ROB_WIDTH-1:0] sid;
    } lookup_t;

    logic [31:0]          value [32];
    logic [ROB_WIDTH-1:0] tag   [32];
    logic [31:0]          busy;

    // Issue is applied after commit so that a same-register issue overrides
    // the commit's busy release; clear then drops every pending tag.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 32; i++) begin
                value[i] <= 32'h0;
                tag[i]   <= '0;
            end
            busy <= 32'h0;
        end else if (rdy_in) begin
            if (commit_valid && commit_reg_id != 5'd0) begin
                value[commit_reg_id] <= commit_val;
                if (busy[commit_reg_id] && tag[commit_reg_id] == commit_rob_id)
                    busy[commit_reg_id] <= 1'b0;
            end
            if (clear) begin
                busy <= 32'h0;
            end else if (dec_ready && issue_rd != 5'd0) begin
                busy[issue_rd] <= 1'b1;
                tag[issue_rd]  <= issue_rob_id;
            end
        end
    end

    function automatic lookup_t lookup(
        input logic [4:0]           rs,
        input logic [31:0]          r_val,
        input logic                 r_busy,
        input logic [ROB_WIDTH-1:0] r_tag,
        input logic                 s_ready,
        input logic [31:0]          s_val,
        input logic                 c_valid,
        input logic [ROB_WIDTH-1:0] c_rob,
        input logic [4:0]           c_reg,
        input logic [31:0]          c_val
    );
        lookup_t res;
        res = '0;
        if (rs == 5'd0) begin
            res = '0;
        end else if (!r_busy) begin
            res.val = r_val;
        end else begin
            res.sid = r_tag;
            if (c_valid && c_reg == rs && c_rob == r_tag)
                res.val = c_val;
            else if (s_ready)
                res.val = s_val;
            else begin
                res.has_dep = 1'b1;
                res.dep     = r_tag;
            end
        end
        return res;
    endfunction

    lookup_t look1;
    lookup_t look2;

    always_comb begin
        look1 = lookup(rs1, value[rs1], busy[rs1], tag[rs1], search_ready_1, search_val_1,
                       commit_valid, commit_rob_id, commit_reg_id, commit_val);
        look2 = lookup(rs2, value[rs2], busy[rs2], tag[rs2], search_ready_2, search_val_2,
                       commit_valid, commit_rob_id, commit_reg_id, commit_val);
    end

    assign val1            = look1.val;
    assign has_dep1        = look1.has_dep;
    assign dep1            = look1.dep;
    assign search_rob_id_1 = look1.sid;
    assign val2            = look2.val;
    assign has_dep2        = look2.has_dep;
    assign dep2            = look2.dep;
    assign search_rob_id_2 = look2.sid;

endmodule
